ahb_lite_master_bridge: RTL

Converts the core's single-outstanding load/store request interface into AHB-Lite master transfers toward the bus decoder and slaves such as the on-chip RAM. It runs a registered address/data-phase FSM and tolerates any number of slave wait states. It replicates write data across byte lanes and extracts and extends read lanes. It rejects misaligned accesses locally, without a bus transfer.

---
 rtl/ahb_lite_master_bridge_pkg.sv | 43 ++++
 rtl/ahb_lite_master_bridge_if.sv | 39 +++
 rtl/ahb_lane_unit.sv | 47 ++++
 rtl/ahb_lite_master_bridge.sv | 127 ++++++++++++
 4 files changed

// File: rtl/ahb_lite_master_bridge_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the core-to-AHB master bridge.
package ahb_lite_master_bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_ACK  = 3'd3,
        ST_MERR = 3'd4
    } state_t;

    // Size 11 has no AHB-Lite meaning for this core, so it is folded into the misaligned case.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ahb_lite_master_bridge_if.sv
// Core request/response and AHB-Lite master signals of the bridge, with bridge-side and far-side views.
interface ahb_lite_master_bridge_if;

    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] wdata_i;
    logic        ack_o;
    logic        err_o;
    logic [31:0] rdata_o;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        input  req_i, we_i, addr_i, size_i, unsigned_i, wdata_i,
        output ack_o, err_o, rdata_o,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output req_i, we_i, addr_i, size_i, unsigned_i, wdata_i,
        input  ack_o, err_o, rdata_o,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/ahb_lane_unit.sv
// Combinational byte-lane steering: write-data replication and read-lane extract with sign/zero extend.
module ahb_lane_unit
    import ahb_lite_master_bridge_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_hrdata,
    output logic [31:0] o_hwdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_hrdata[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_hrdata[7:0];
            2'd1:    w_byte = i_hrdata[15:8];
            2'd2:    w_byte = i_hrdata[23:16];
            default: w_byte = i_hrdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_hrdata[31:16] : i_hrdata[15:0];
    end

    always_comb begin
        o_hwdata = i_wdata;
        o_rdata  = i_hrdata;
        case (i_size)
            SIZE_BYTE: begin
                o_hwdata = {4{i_wdata[7:0]}};
                o_rdata  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                o_hwdata = {2{i_wdata[15:0]}};
                o_rdata  = {{16{~i_unsigned & w_half[15]}}, w_half};
            end
            default: begin
                o_hwdata = i_wdata;
                o_rdata  = i_hrdata;
            end
        endcase
    end

endmodule

// File: rtl/ahb_lite_master_bridge.sv
// Single-outstanding load/store to AHB-Lite SINGLE transfer bridge with registered address/data-phase FSM.
//   state | meaning
//   IDLE  | bus idle, sampling req_i
//   ADDR  | NONSEQ on bus, waiting for HREADY to close address phase
//   DATA  | data phase, waiting for HREADY to take response
//   ACK   | ack_o pulse being retired, no new request accepted
//   MERR  | misaligned request, answer with error without bus traffic
module ahb_lite_master_bridge
    import ahb_lite_master_bridge_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    ahb_lite_master_bridge_if.master  bus
);

    state_t      r_state;
    logic [31:0] r_haddr;
    logic [1:0]  r_htrans;
    logic        r_hwrite;
    logic [2:0]  r_hsize;
    logic [31:0] r_hwdata;
    logic [31:0] r_wdata;
    logic        r_unsigned;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_rdata;

    logic [31:0] w_hwdata;
    logic [31:0] w_rdata;

    ahb_lane_unit u_lane (
        .i_size     (r_hsize[1:0]),
        .i_addr_lo  (r_haddr[1:0]),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_hrdata   (bus.HRDATA),
        .o_hwdata   (w_hwdata),
        .o_rdata    (w_rdata)
    );

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_haddr    <= '0;
            r_htrans   <= HTRANS_IDLE;
            r_hwrite   <= 1'b0;
            r_hsize    <= HSIZE_BYTE;
            r_hwdata   <= '0;
            r_wdata    <= '0;
            r_unsigned <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack    <= 1'b0;
                    r_err    <= 1'b0;
                    r_htrans <= HTRANS_IDLE;
                    if (bus.req_i) begin
                        if (is_misaligned(bus.size_i, bus.addr_i[1:0])) begin
                            r_state <= ST_MERR;
                        end else begin
                            r_haddr    <= bus.addr_i;
                            r_hwrite   <= bus.we_i;
                            r_hsize    <= {1'b0, bus.size_i};
                            r_wdata    <= bus.wdata_i;
                            r_unsigned <= bus.unsigned_i;
                            r_htrans   <= HTRANS_NONSEQ;
                            r_state    <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus.HREADY) begin
                        r_htrans <= HTRANS_IDLE;
                        if (r_hwrite) begin
                            r_hwdata <= w_hwdata;
                        end
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // HRESP alone is only the first cycle of a two-cycle ERROR; act on HREADY.
                    if (bus.HREADY) begin
                        r_ack <= 1'b1;
                        r_err <= (bus.HRESP == HRESP_ERROR);
                        if ((bus.HRESP == HRESP_OKAY) && !r_hwrite) begin
                            r_rdata <= w_rdata;
                        end
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_MERR: begin
                    r_ack   <= 1'b1;
                    r_err   <= 1'b1;
                    r_state <= ST_ACK;
                end
                default: begin
                    r_htrans <= HTRANS_IDLE;
                    r_ack    <= 1'b0;
                    r_err    <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack_o   = r_ack;
    assign bus.err_o   = r_err;
    assign bus.rdata_o = r_rdata;
    assign bus.HADDR   = r_haddr;
    assign bus.HTRANS  = r_htrans;
    assign bus.HWRITE  = r_hwrite;
    assign bus.HSIZE   = r_hsize;
    assign bus.HBURST  = HBURST_SINGLE;
    assign bus.HPROT   = HPROT_VAL;
    assign bus.HWDATA  = r_hwdata;

endmodule
